// File: rtl/regfile_2r1w_param.sv
// regfile_2r1w_param: 2-read/1-write register file with write-first bypass, zero register and bulk-clear sweep
module regfile_2r1w_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid2,
    input  logic              clr_req,
    output logic              busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, rd1_val, rd2_val;
    logic              rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d, wr_ok;
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    assign busy    = (state_q == S_CLEAR);
    assign rdata1  = rdata1_q;
    assign rdata2  = rdata2_q;
    assign rvalid1 = rvalid1_q;
    assign rvalid2 = rvalid2_q;
    assign wr_ok = we && !busy && ({1'b0, waddr} < DEPTH_L) && !(ZERO_REG != 0 && waddr == '0);
    // Range checks are done on the full address; the array index only needs the low bits.
    assign rd1_val = ((ZERO_REG != 0 && raddr1 == '0) || ({1'b0, raddr1} >= DEPTH_L)) ? '0 :
                     (wr_ok && waddr == raddr1) ? wdata : mem_q[raddr1[IW-1:0]];
    assign rd2_val = ((ZERO_REG != 0 && raddr2 == '0) || ({1'b0, raddr2} >= DEPTH_L)) ? '0 :
                     (wr_ok && waddr == raddr2) ? wdata : mem_q[raddr2[IW-1:0]];
    always_comb begin
        mem_d = mem_q;
        if (state_q == S_CLEAR) mem_d[idx_q[IW-1:0]] = '0;
        else if (wr_ok) mem_d[waddr[IW-1:0]] = wdata;
        rvalid1_d = re1 && !busy;
        rvalid2_d = re2 && !busy;
        rdata1_d  = rvalid1_d ? rd1_val : rdata1_q;
        rdata2_d  = rvalid2_d ? rd2_val : rdata2_q;
        state_d   = (state_q == S_IDLE) ? (clr_req ? S_CLEAR : S_IDLE) :
                    ((idx_q == LAST) ? S_IDLE : S_CLEAR);
        idx_d     = (state_q == S_CLEAR && idx_q != LAST) ? idx_q + 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            state_q   <= S_IDLE;
            idx_q     <= '0;
        end else begin
            mem_q     <= mem_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            rvalid1_q <= rvalid1_d;
            rvalid2_q <= rvalid2_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
        end
    end
endmodule

// File: tb/tb_regfile_2r1w_param.sv
// tb_regfile_2r1w_param: directed checks of reads, bypass, zero register, clear sweep and a DEPTH=16 instance
module tb_regfile_2r1w_param;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0, re1 = 1'b0, re2 = 1'b0, clr_req = 1'b0;
    logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2, busy;
    logic        d_we = 1'b0, d_re1 = 1'b0, d_re2 = 1'b0, d_clr = 1'b0;
    logic [4:0]  d_waddr = '0, d_raddr1 = '0, d_raddr2 = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata1, d_rdata2;
    logic        d_rvalid1, d_rvalid2, d_busy;
    int          total = 0;
    int          bad = 0;
    int          n;

    always #5 clk = ~clk;

    regfile_2r1w_param u_dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .rvalid2(rvalid2),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_2r1w_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .ZERO_REG(1)) u_d16 (
        .clk(clk), .reset(reset), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
        .re1(d_re1), .raddr1(d_raddr1), .rdata1(d_rdata1), .rvalid1(d_rvalid1),
        .re2(d_re2), .raddr2(d_raddr2), .rdata2(d_rdata2), .rvalid2(d_rvalid2),
        .clr_req(d_clr), .busy(d_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rdata1", rdata1, 0);
        chk("rst_rvalid1", {31'b0, rvalid1}, 0);
        chk("rst_rvalid2", {31'b0, rvalid2}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            re1 = 1'b1; raddr1 = 5'(i);
            re2 = 1'b1; raddr2 = 5'(31 - i);
            tick();
            chk($sformatf("init_rd1_%0d", i), rdata1, 0);
            chk($sformatf("init_rd2_%0d", i), rdata2, 0);
            chk($sformatf("init_rv1_%0d", i), {31'b0, rvalid1}, 1);
            chk($sformatf("init_rv2_%0d", i), {31'b0, rvalid2}, 1);
        end
        re1 = 1'b0; re2 = 1'b0;
        tick();
        chk("rv1_drop", {31'b0, rvalid1}, 0);
        // Two writes then a dual read
        we = 1'b1; waddr = 5'd1; wdata = 32'd12;
        tick();
        waddr = 5'd2; wdata = 32'd24;
        tick();
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        tick();
        chk("rd_a1", rdata1, 12);
        chk("rd_a2", rdata2, 24);
        chk("rv1_a", {31'b0, rvalid1}, 1);
        chk("rv2_a", {31'b0, rvalid2}, 1);
        re1 = 1'b0; re2 = 1'b0;
        tick();
        chk("hold_rd1", rdata1, 12);
        chk("hold_rv1", {31'b0, rvalid1}, 0);
        re1 = 1'b1; raddr1 = 5'd2; re2 = 1'b1; raddr2 = 5'd2;
        tick();
        chk("same_rd1", rdata1, 24);
        chk("same_rd2", rdata2, 24);
        // Write-first bypass
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd1;
        tick();
        chk("byp_rd1", rdata1, 32'hDEADBEEF);
        chk("byp_rd2", rdata2, 12);
        waddr = 5'd0; wdata = 32'd7; raddr1 = 5'd0; raddr2 = 5'd5;
        tick();
        chk("zero_byp", rdata1, 0);
        chk("arr_rd5", rdata2, 32'hDEADBEEF);
        we = 1'b0;
        tick();
        chk("zero_arr", rdata1, 0);
        re1 = 1'b0; re2 = 1'b0;
        // Fill then sweep
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i + 100);
            tick();
        end
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd3;
        tick();
        chk("fill_31", rdata1, 131);
        chk("fill_3", rdata2, 103);
        re1 = 1'b0; re2 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("busy_rise", {31'b0, busy}, 1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            we = (n == 1); waddr = 5'd3; wdata = 32'd99;
            re1 = (n == 1); raddr1 = 5'd3;
            tick();
            if (n == 1) begin
                chk("busy_rv1", {31'b0, rvalid1}, 0);
                chk("busy_hold", rdata1, 131);
            end
        end
        we = 1'b0; re1 = 1'b0;
        chk("busy_len", n, 32);
        for (int i = 0; i < 32; i++) begin
            re1 = 1'b1; raddr1 = 5'(i); re2 = 1'b1; raddr2 = 5'(i);
            tick();
            chk($sformatf("clr_rd1_%0d", i), rdata1, 0);
            chk($sformatf("clr_rd2_%0d", i), rdata2, 0);
        end
        re1 = 1'b0; re2 = 1'b0;
        // Reset during sweep
        we = 1'b1; waddr = 5'd20; wdata = 32'd55;
        tick();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd20;
        tick();
        chk("w55", rdata1, 55);
        re1 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        chk("mid_busy", {31'b0, busy}, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_rd1", rdata1, 0);
        #1;
        reset = 1'b1;
        re1 = 1'b1; raddr1 = 5'd20;
        tick();
        chk("post_rst20", rdata1, 0);
        chk("post_rst_rv", {31'b0, rvalid1}, 1);
        re1 = 1'b0;
        // Write and clr_req together; clr_req during busy is ignored
        we = 1'b1; waddr = 5'd7; wdata = 32'd77; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            clr_req = (n == 5);
            tick();
        end
        clr_req = 1'b0;
        chk("busy_len2", n, 32);
        tick();
        chk("no_restart", {31'b0, busy}, 0);
        re1 = 1'b1; raddr1 = 5'd7;
        tick();
        chk("wclr_7", rdata1, 0);
        re1 = 1'b0;
        // DEPTH=16 instance: out-of-range address
        d_we = 1'b1; d_waddr = 5'd20; d_wdata = 32'd9;
        d_re1 = 1'b1; d_raddr1 = 5'd20;
        tick();
        chk("d16_byp20", d_rdata1, 0);
        chk("d16_rv20", {31'b0, d_rvalid1}, 1);
        d_we = 1'b0; d_re2 = 1'b1; d_raddr2 = 5'd4;
        tick();
        chk("d16_rd20", d_rdata1, 0);
        chk("d16_alias4", d_rdata2, 0);
        d_re1 = 1'b0; d_re2 = 1'b0;
        d_we = 1'b1; d_waddr = 5'd15; d_wdata = 32'd9;
        tick();
        d_we = 1'b0; d_re1 = 1'b1; d_raddr1 = 5'd15;
        tick();
        chk("d16_rd15", d_rdata1, 9);
        d_re1 = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
